// File: rtl/lunc_pkg.sv
`default_nettype none
// ============================================================================
// Module   : lunc_pkg
// Brief    : Shared types and constants for the lunc_sched byte scheduler.
// Revision : 1.0  initial release
// ============================================================================
package lunc_pkg;

    typedef enum logic [1:0] {
        MODE_N = 2'd0,
        MODE_L = 2'd1,
        MODE_U = 2'd2,
        MODE_C = 2'd3
    } mode_t;

    typedef enum logic [0:0] {
        PS_NORMAL   = 1'b0,
        PS_ESC_SEEN = 1'b1
    } pstate_t;

    localparam logic [7:0] ESC_DEFAULT = 8'h1b;
    localparam logic [7:0] CMD_L       = 8'h4c;
    localparam logic [7:0] CMD_U       = 8'h55;
    localparam logic [7:0] CMD_N       = 8'h4e;
    localparam logic [7:0] CMD_C       = 8'h43;

endpackage
`default_nettype wire

// File: rtl/lunc_xform.sv
`default_nettype none
// ============================================================================
// Module   : lunc_xform
// Brief    : Combinational case transform of one byte under a channel mode.
// Revision : 1.0  initial release
// ============================================================================
module lunc_xform
    import lunc_pkg::*;
(
    input  logic [7:0] data_in,
    input  mode_t      mode,
    output logic [7:0] data_out
);

    always_comb begin
        data_out = data_in;
        case (mode)
            MODE_L:  if (!data_in[5]) data_out = data_in + 8'h20;
            MODE_U:  if (data_in[5])  data_out = data_in - 8'h20;
            MODE_C:  data_out = data_in[5] ? (data_in - 8'h20) : (data_in + 8'h20);
            default: data_out = data_in;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/lunc_sched.sv
`default_nettype none
// ============================================================================
// Module   : lunc_sched
// Brief    : Round-robin byte scheduler with per-channel escape/mode parsers.
//            Optional macro LUNC_SCHED_ESC_PASS_EN also forwards ESC and
//            command bytes untransformed.
// Revision : 1.0  initial release
// ============================================================================
module lunc_sched
    import lunc_pkg::*;
#(
    parameter int         NCH = 4,
    parameter logic [7:0] ESC = ESC_DEFAULT
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [NCH-1:0]           req_valid,
    input  logic [8*NCH-1:0]         req_data,
    output logic [NCH-1:0]           req_ready,
    output logic                     out_valid,
    output logic [7:0]               out_data,
    output logic [$clog2(NCH)-1:0]   out_chan,
    input  logic                     out_ready,
    output logic [2*NCH-1:0]         mode
);

    localparam int CW = $clog2(NCH);
`ifdef LUNC_SCHED_ESC_PASS_EN
    localparam logic C_PASS = 1'b1;
`else
    localparam logic C_PASS = 1'b0;
`endif

    mode_t          r_mode [NCH];
    pstate_t        r_ps   [NCH];
    logic [CW-1:0]  r_rr;
    logic           r_out_valid;
    logic [7:0]     r_out_data;
    logic [CW-1:0]  r_out_chan;

    logic           w_any;
    logic [CW-1:0]  w_gnt;
    logic           w_xfer;
    logic [7:0]     w_byte;
    logic [7:0]     w_xbyte;
    mode_t          w_cur_mode;
    pstate_t        w_cur_ps;
    mode_t          w_mode_nxt;
    pstate_t        w_ps_nxt;
    logic           w_emit;
    logic [7:0]     w_emit_byte;

    // Round-robin search starting at r_rr
    always_comb begin
        w_any = 1'b0;
        w_gnt = '0;
        for (int k = 0; k < NCH; k++) begin
            int idx;
            idx = (int'(r_rr) + k) % NCH;
            if (!w_any && req_valid[idx]) begin
                w_any = 1'b1;
                w_gnt = CW'(idx);
            end
        end
    end

    assign w_xfer = w_any && (!r_out_valid || out_ready) && !reset;

    always_comb begin
        req_ready = '0;
        if (w_xfer) req_ready[w_gnt] = 1'b1;
    end

    assign w_byte     = req_data[int'(w_gnt)*8 +: 8];
    assign w_cur_mode = r_mode[w_gnt];
    assign w_cur_ps   = r_ps[w_gnt];

    lunc_xform u_xform (
        .data_in  (w_byte),
        .mode     (w_cur_mode),
        .data_out (w_xbyte)
    );

    // Parser next state for the granted channel only
    always_comb begin
        w_ps_nxt    = w_cur_ps;
        w_mode_nxt  = w_cur_mode;
        w_emit      = 1'b0;
        w_emit_byte = w_xbyte;
        case (w_cur_ps)
            PS_NORMAL: begin
                if (w_byte == ESC) begin
                    w_ps_nxt    = PS_ESC_SEEN;
                    w_emit      = C_PASS;
                    w_emit_byte = w_byte;
                end else begin
                    w_emit = 1'b1;
                end
            end
            PS_ESC_SEEN: begin
                w_ps_nxt = PS_NORMAL;
                if (w_byte == ESC) begin
                    w_emit      = 1'b1;
                    w_emit_byte = w_byte;
                end else if (w_byte == CMD_L || w_byte == CMD_U ||
                             w_byte == CMD_N || w_byte == CMD_C) begin
                    w_emit      = C_PASS;
                    w_emit_byte = w_byte;
                    if (w_byte == CMD_L)      w_mode_nxt = MODE_L;
                    else if (w_byte == CMD_U) w_mode_nxt = MODE_U;
                    else if (w_byte == CMD_C) w_mode_nxt = MODE_C;
                    else                      w_mode_nxt = MODE_N;
                end else begin
                    w_emit = 1'b1;
                end
            end
            default: w_ps_nxt = PS_NORMAL;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_rr        <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_chan  <= '0;
            for (int i = 0; i < NCH; i++) begin
                r_mode[i] <= MODE_N;
                r_ps[i]   <= PS_NORMAL;
            end
        end else begin
            if (w_xfer) begin
                r_rr          <= CW'((int'(w_gnt) + 1) % NCH);
                r_mode[w_gnt] <= w_mode_nxt;
                r_ps[w_gnt]   <= w_ps_nxt;
            end
            if (w_xfer && w_emit) begin
                r_out_valid <= 1'b1;
                r_out_data  <= w_emit_byte;
                r_out_chan  <= w_gnt;
            end else if (out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_chan  = r_out_chan;

    generate
        for (genvar i = 0; i < NCH; i++) begin : g_mode
            assign mode[2*i +: 2] = r_mode[i];
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_lunc_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_lunc_sched
// Brief    : Self-checking bench for lunc_sched against a behavioural model.
// Revision : 1.0  initial release
// ============================================================================
module tb_lunc_sched;

    localparam int         NCH = 4;
    localparam logic [7:0] ESC = 8'h1b;
`ifdef LUNC_SCHED_ESC_PASS_EN
    localparam bit PASS = 1'b1;
`else
    localparam bit PASS = 1'b0;
`endif

    logic               clock = 1'b0;
    logic               reset = 1'b1;
    logic [NCH-1:0]     req_valid = '0;
    logic [8*NCH-1:0]   req_data = '0;
    logic [NCH-1:0]     req_ready;
    logic               out_valid;
    logic [7:0]         out_data;
    logic [1:0]         out_chan;
    logic               out_ready = 1'b0;
    logic [2*NCH-1:0]   mode;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    lunc_sched #(.NCH(NCH), .ESC(ESC)) dut (
        .clock     (clock),
        .reset     (reset),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_chan  (out_chan),
        .out_ready (out_ready),
        .mode      (mode)
    );

    // Behavioural model state
    int             m_rr;
    int             m_mode [NCH];
    bit             m_esc  [NCH];
    bit             m_ov;
    logic [7:0]     m_od;
    logic [1:0]     m_oc;
    logic [NCH-1:0] m_ready;
    bit             m_xfer;
    int             m_g;

    function automatic logic [7:0] ref_xf(input logic [7:0] b, input int md);
        case (md)
            1:       return b | 8'h20;
            2:       return b & 8'hdf;
            3:       return b ^ 8'h20;
            default: return b;
        endcase
    endfunction

    function automatic logic [2*NCH-1:0] mvec();
        logic [2*NCH-1:0] v;
        for (int k = 0; k < NCH; k++) v[2*k +: 2] = 2'(m_mode[k]);
        return v;
    endfunction

    function automatic logic [8*NCH-1:0] put(input int ch, input logic [7:0] b);
        logic [8*NCH-1:0] d;
        d = '0;
        d[8*ch +: 8] = b;
        return d;
    endfunction

    // Drive inputs and predict the grant for this cycle
    task automatic apply(input logic [NCH-1:0] v, input logic [8*NCH-1:0] d,
                         input logic orr, input logic rst);
        req_valid = v; req_data = d; out_ready = orr; reset = rst;
        #1;
        m_xfer = 0; m_g = 0; m_ready = '0;
        if (!rst && (!m_ov || orr)) begin
            for (int k = 0; k < NCH; k++) begin
                int c;
                c = (m_rr + k) % NCH;
                if (!m_xfer && v[c]) begin m_xfer = 1; m_g = c; end
            end
        end
        if (m_xfer) m_ready[m_g] = 1'b1;
    endtask

    // Advance one clock and update the model from the accepted byte
    task automatic tick();
        logic [7:0] b, eb;
        bit emit;
        @(posedge clock); #1;
        if (reset) begin
            m_rr = 0; m_ov = 0; m_od = 0; m_oc = 0;
            for (int k = 0; k < NCH; k++) begin m_mode[k] = 0; m_esc[k] = 0; end
        end else begin
            emit = 0; eb = 0;
            if (m_xfer) begin
                b = req_data[8*m_g +: 8];
                if (!m_esc[m_g]) begin
                    if (b == ESC) begin m_esc[m_g] = 1; emit = PASS; eb = b; end
                    else begin emit = 1; eb = ref_xf(b, m_mode[m_g]); end
                end else begin
                    m_esc[m_g] = 0;
                    case (b)
                        ESC:   begin emit = 1; eb = b; end
                        8'h4c: begin m_mode[m_g] = 1; emit = PASS; eb = b; end
                        8'h55: begin m_mode[m_g] = 2; emit = PASS; eb = b; end
                        8'h4e: begin m_mode[m_g] = 0; emit = PASS; eb = b; end
                        8'h43: begin m_mode[m_g] = 3; emit = PASS; eb = b; end
                        default: begin emit = 1; eb = ref_xf(b, m_mode[m_g]); end
                    endcase
                end
                m_rr = (m_g + 1) % NCH;
            end
            if (emit) begin m_ov = 1; m_od = eb; m_oc = m_g[1:0]; end
            else if (out_ready) m_ov = 0;
        end
    endtask

    task automatic do_reset();
        apply('0, '0, 1'b1, 1'b1);
        tick();
    endtask

    task automatic test_reset();
        for (int n = 0; n < 2; n++) begin
            apply('0, '0, 1'b1, 1'b1);
            checks++;
            if (req_ready !== 4'b0) begin
                errors++; $display("FAIL reset_ready got %h want 0", req_ready);
            end
            tick();
            checks++;
            if ({out_valid, out_data, out_chan, mode} !== 19'b0) begin
                errors++;
                $display("FAIL reset_state got v=%b d=%h c=%h m=%h want all zero",
                         out_valid, out_data, out_chan, mode);
            end
        end
    endtask

    task automatic test_single_channel();
        logic [7:0] seq [7] = '{8'h41, 8'h1b, 8'h4c, 8'h41, 8'h62, 8'h00, 8'h00};
        logic [7:0] q [$];
        logic [7:0] exp_q [$];
`ifdef LUNC_SCHED_ESC_PASS_EN
        exp_q = '{8'h41, 8'h1b, 8'h4c, 8'h61, 8'h62};
`else
        exp_q = '{8'h41, 8'h61, 8'h62};
`endif
        do_reset();
        for (int n = 0; n < 7; n++) begin
            apply((n < 5) ? 4'b0001 : 4'b0000, put(0, seq[n]), 1'b1, 1'b0);
            checks++;
            if (req_ready !== m_ready) begin
                errors++; $display("FAIL single_ready got %h want %h", req_ready, m_ready);
            end
            tick();
            checks++;
            if ({out_valid, out_data, out_chan, mode} !== {m_ov, m_od, m_oc, mvec()}) begin
                errors++;
                $display("FAIL single_out got %b/%h/%h/%h want %b/%h/%h/%h", out_valid,
                         out_data, out_chan, mode, m_ov, m_od, m_oc, mvec());
            end
            if (n == 2) begin
                checks++;
                if (mode[1:0] !== 2'd1) begin
                    errors++; $display("FAIL single_mode got %0d want 1", mode[1:0]);
                end
            end
            if (out_valid) q.push_back(out_data);
        end
        checks++;
        if (q !== exp_q) begin
            errors++; $display("FAIL single_stream got %p want %p", q, exp_q);
        end
    endtask

    task automatic test_round_robin();
        do_reset();
        for (int n = 0; n < 8; n++) begin
            apply(4'b1111, {4{8'h61}}, 1'b1, 1'b0);
            checks++;
            if (req_ready !== m_ready) begin
                errors++; $display("FAIL rr_ready got %h want %h", req_ready, m_ready);
            end
            tick();
            checks++;
            if (out_valid !== 1'b1 || out_chan !== 2'(n % 4) || out_data !== 8'h61) begin
                errors++;
                $display("FAIL rr_chan got v=%b c=%0d d=%h want v=1 c=%0d d=61",
                         out_valid, out_chan, out_data, n % 4);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [7:0] held;
        do_reset();
        apply(4'b0001, put(0, 8'h61), 1'b1, 1'b0);
        tick();
        held = out_data;
        for (int n = 0; n < 3; n++) begin
            apply(4'b1111, {8'h44, 8'h43, 8'h42, 8'h41}, 1'b0, 1'b0);
            checks++;
            if (req_ready !== 4'b0) begin
                errors++; $display("FAIL bp_ready got %h want 0", req_ready);
            end
            tick();
            checks++;
            if (out_valid !== 1'b1 || out_data !== held || out_data !== 8'h61) begin
                errors++;
                $display("FAIL bp_hold got v=%b d=%h want v=1 d=61", out_valid, out_data);
            end
        end
        apply(4'b1111, {8'h44, 8'h43, 8'h42, 8'h41}, 1'b1, 1'b0);
        checks++;
        if (req_ready !== m_ready || req_ready !== 4'b0010) begin
            errors++; $display("FAIL bp_release got %h want 0010", req_ready);
        end
        tick();
        checks++;
        if ({out_valid, out_data, out_chan} !== {m_ov, m_od, m_oc}) begin
            errors++;
            $display("FAIL bp_resume got %b/%h/%h want %b/%h/%h", out_valid, out_data,
                     out_chan, m_ov, m_od, m_oc);
        end
    endtask

    task automatic test_esc_literal();
        logic [7:0] seq [7] = '{8'h1b, 8'h43, 8'h1b, 8'h1b, 8'h7a, 8'h00, 8'h00};
        logic [7:0] q [$];
        logic [7:0] exp_q [$];
`ifdef LUNC_SCHED_ESC_PASS_EN
        exp_q = '{8'h1b, 8'h43, 8'h1b, 8'h1b, 8'h5a};
`else
        exp_q = '{8'h1b, 8'h5a};
`endif
        do_reset();
        for (int n = 0; n < 7; n++) begin
            apply((n < 5) ? 4'b0010 : 4'b0000, put(1, seq[n]), 1'b1, 1'b0);
            tick();
            checks++;
            if ({out_valid, out_data, out_chan, mode} !== {m_ov, m_od, m_oc, mvec()}) begin
                errors++;
                $display("FAIL esc_out got %b/%h/%h/%h want %b/%h/%h/%h", out_valid,
                         out_data, out_chan, mode, m_ov, m_od, m_oc, mvec());
            end
            if (out_valid) q.push_back(out_data);
        end
        checks++;
        if (q !== exp_q || mode[3:2] !== 2'd3) begin
            errors++; $display("FAIL esc_stream got %p mode=%0d want %p mode=3", q, mode[3:2], exp_q);
        end
    endtask

    task automatic test_reset_mid_escape();
        do_reset();
        apply(4'b0100, put(2, 8'h1b), 1'b1, 1'b0);
        tick();
        do_reset();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++; $display("FAIL midrst_drop got v=%b want 0", out_valid);
        end
        apply(4'b0100, put(2, 8'h4c), 1'b1, 1'b0);
        tick();
        checks++;
        if (out_valid !== 1'b1 || out_data !== 8'h4c || out_chan !== 2'd2 || mode !== 8'h00) begin
            errors++;
            $display("FAIL midrst_out got v=%b d=%h c=%0d m=%h want v=1 d=4c c=2 m=00",
                     out_valid, out_data, out_chan, mode);
        end
    endtask

    task automatic test_cmd_pass();
        logic [7:0] seq [5] = '{8'h1b, 8'h55, 8'h61, 8'h00, 8'h00};
        logic [7:0] q [$];
        logic [7:0] exp_q [$];
`ifdef LUNC_SCHED_ESC_PASS_EN
        exp_q = '{8'h1b, 8'h55, 8'h41};
`else
        exp_q = '{8'h41};
`endif
        do_reset();
        for (int n = 0; n < 5; n++) begin
            apply((n < 3) ? 4'b0001 : 4'b0000, put(0, seq[n]), 1'b1, 1'b0);
            tick();
            if (out_valid) q.push_back(out_data);
        end
        checks++;
        if (q !== exp_q || mode[1:0] !== 2'd2) begin
            errors++; $display("FAIL cmd_stream got %p mode=%0d want %p mode=2", q, mode[1:0], exp_q);
        end
    endtask

    task automatic test_random();
        logic [7:0] alpha [10] = '{8'h1b, 8'h4c, 8'h55, 8'h4e, 8'h43,
                                   8'h41, 8'h61, 8'h7a, 8'h5a, 8'h30};
        logic [8*NCH-1:0] d;
        do_reset();
        for (int n = 0; n < 600; n++) begin
            for (int k = 0; k < NCH; k++) d[8*k +: 8] = alpha[$urandom_range(0, 9)];
            apply(4'($urandom), d, ($urandom_range(0, 3) != 0), ($urandom_range(0, 63) == 0));
            checks++;
            if (req_ready !== m_ready) begin
                errors++; $display("FAIL rand_ready cyc %0d got %h want %h", n, req_ready, m_ready);
            end
            tick();
            checks++;
            if ({out_valid, out_data, out_chan, mode} !== {m_ov, m_od, m_oc, mvec()}) begin
                errors++;
                $display("FAIL rand_out cyc %0d got %b/%h/%h/%h want %b/%h/%h/%h", n, out_valid,
                         out_data, out_chan, mode, m_ov, m_od, m_oc, mvec());
            end
        end
    endtask

    initial begin
        m_rr = 0; m_ov = 0; m_od = 0; m_oc = 0; m_xfer = 0; m_g = 0; m_ready = '0;
        for (int k = 0; k < NCH; k++) begin m_mode[k] = 0; m_esc[k] = 0; end
        repeat (2) @(posedge clock);
        #1;
        test_reset();
        test_single_channel();
        test_round_robin();
        test_backpressure();
        test_esc_literal();
        test_reset_mid_escape();
        test_cmd_pass();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
